// File: rtl/axi_addr_arb.sv
// ---------------------------------------------------------------------------
// axi_addr_arb
//
// Address-channel arbiter for one AXI address path (AR or AW). Each of the
// NUM_MST masters feeds its own DEPTH-entry FIFO. A registered output stage
// takes requests from those FIFOs round-robin and forwards them to a single
// subordinate. Every forwarded request carries the master index in the top
// bits of s_mid_id. Each master may have at most MAX_OUT granted requests in
// flight. The response router returns a done pulse for each completed
// transaction, and that pulse frees one slot.
//
// Handshake (both sides): a transfer happens on a rising CLK edge where
// valid and ready are both high. A producer holding valid high keeps its
// payload stable until the transfer. m_ready depends only on FIFO state, and
// s_valid and s_* come straight from flops.
//
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   m_valid/m_ready per-master request handshake
//   m_addr/id/size/len/burst   per-master payload, flattened (master 0 = LSBs)
//   s_valid/s_ready subordinate handshake
//   s_addr/s_mid_id/s_size/s_len/s_burst   forwarded payload, {idx,id} tag
//   done_valid/done_mid        completion pulse and its master index
//   outstanding     per-master in-flight counts, flattened
//   err             sticky: completion for an idle or nonexistent master
// ---------------------------------------------------------------------------
module axi_addr_arb #(
  parameter int NUM_MST = 3,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 32,
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 4,
  parameter int MIDX_W  = $clog2(NUM_MST)
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic [NUM_MST-1:0]                      m_valid,
  output logic [NUM_MST-1:0]                      m_ready,
  input  logic [NUM_MST*ADDR_W-1:0]               m_addr,
  input  logic [NUM_MST*ID_W-1:0]                 m_id,
  input  logic [NUM_MST*3-1:0]                    m_size,
  input  logic [NUM_MST*8-1:0]                    m_len,
  input  logic [NUM_MST*2-1:0]                    m_burst,
  output logic                                    s_valid,
  input  logic                                    s_ready,
  output logic [ADDR_W-1:0]                       s_addr,
  output logic [MIDX_W+ID_W-1:0]                  s_mid_id,
  output logic [2:0]                              s_size,
  output logic [7:0]                              s_len,
  output logic [1:0]                              s_burst,
  input  logic                                    done_valid,
  input  logic [MIDX_W-1:0]                       done_mid,
  output logic [NUM_MST*$clog2(MAX_OUT+1)-1:0]    outstanding,
  output logic                                    err
);

  localparam int CW = $clog2(MAX_OUT+1);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = ADDR_W + ID_W + 3 + 8 + 2;

  localparam logic [CW-1:0]     CNT_ONE = 1;
  localparam logic [CW-1:0]     CNT_MAX = CW'(MAX_OUT);
  localparam logic [AW:0]       PTR_ONE = 1;
  localparam logic [MIDX_W-1:0] IDX_ONE = 1;
  localparam logic [MIDX_W-1:0] IDX_LST = MIDX_W'(NUM_MST-1);

  // FIFO storage and pointers. The pointer MSB is a wrap bit that tells a
  // full FIFO from an empty one.
  logic [PW-1:0]       r_mem [NUM_MST][DEPTH];
  logic [AW:0]         r_wr  [NUM_MST];
  logic [AW:0]         r_rd  [NUM_MST];
  logic [CW-1:0]       r_cnt [NUM_MST];
  logic [MIDX_W-1:0]   r_ptr;
  logic                r_s_valid;
  logic [ADDR_W-1:0]   r_s_addr;
  logic [MIDX_W+ID_W-1:0] r_s_mid_id;
  logic [2:0]          r_s_size;
  logic [7:0]          r_s_len;
  logic [1:0]          r_s_burst;
  logic                r_err;

  logic [PW-1:0]       w_in   [NUM_MST];
  logic [NUM_MST-1:0]  w_full;
  logic [NUM_MST-1:0]  w_empty;
  logic [NUM_MST-1:0]  w_elig;
  logic [NUM_MST-1:0]  w_push;
  logic [NUM_MST-1:0]  w_pop;
  logic [NUM_MST-1:0]  w_dec;
  logic                w_load;
  logic                w_gnt_any;
  logic [MIDX_W-1:0]   w_gnt_idx;
  logic [PW-1:0]       w_head;
  logic                w_done_bad;

  // FIFO status, eligibility and input packing
  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      w_in[i]    = {m_addr[i*ADDR_W +: ADDR_W], m_id[i*ID_W +: ID_W],
                    m_size[i*3 +: 3], m_len[i*8 +: 8], m_burst[i*2 +: 2]};
      w_empty[i] = (r_wr[i] == r_rd[i]);
      w_full[i]  = (r_wr[i][AW] != r_rd[i][AW]) &&
                   (r_wr[i][AW-1:0] == r_rd[i][AW-1:0]);
      w_elig[i]  = !w_empty[i] && (r_cnt[i] < CNT_MAX);
      w_push[i]  = m_valid[i] && !w_full[i];
    end
  end

  // Ready is taken from full only. A pop in the same cycle does not raise it.
  assign m_ready = ~w_full;

  // Round-robin pick. The scan starts at r_ptr and wraps. A grant happens
  // only when the output register is free or is being drained this cycle.
  always_comb begin
    int t;
    t         = 0;
    w_load    = !r_s_valid || s_ready;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_pop     = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      t = int'(r_ptr) + k;
      if (t >= NUM_MST) t = t - NUM_MST;
      for (int j = 0; j < NUM_MST; j++) begin
        if (w_load && !w_gnt_any && (j == t) && w_elig[j]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = MIDX_W'(j);
          w_pop[j]  = 1'b1;
        end
      end
    end
  end

  // Head of the granted FIFO
  always_comb begin
    w_head = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (w_pop[i]) w_head = r_mem[i][r_rd[i][AW-1:0]];
    end
  end

  // Completion decode. Out-of-range indices never match any master.
  always_comb begin
    w_done_bad = done_valid && (int'(done_mid) >= NUM_MST);
    for (int i = 0; i < NUM_MST; i++) begin
      w_dec[i] = 1'b0;
      if (done_valid && (done_mid == MIDX_W'(i))) begin
        if (r_cnt[i] == '0) w_done_bad = 1'b1;
        else                w_dec[i]   = 1'b1;
      end
    end
  end

  // FIFO storage has no reset. Entries are only read after they are written.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_MST; i++) begin
      if (w_push[i]) r_mem[i][r_wr[i][AW-1:0]] <= w_in[i];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_MST; i++) begin
        r_wr[i]  <= '0;
        r_rd[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MST; i++) begin
        if (w_push[i]) r_wr[i] <= r_wr[i] + PTR_ONE;
        if (w_pop[i])  r_rd[i] <= r_rd[i] + PTR_ONE;
        // A grant and a done on the same master in one cycle cancel out.
        if (w_pop[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + CNT_ONE;
        else if (!w_pop[i] && w_dec[i]) r_cnt[i] <= r_cnt[i] - CNT_ONE;
      end
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s_valid  <= 1'b0;
      r_s_addr   <= '0;
      r_s_mid_id <= '0;
      r_s_size   <= '0;
      r_s_len    <= '0;
      r_s_burst  <= '0;
      r_ptr      <= '0;
    end else if (w_load) begin
      r_s_valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_s_addr   <= w_head[PW-1 -: ADDR_W];
        r_s_mid_id <= {w_gnt_idx, w_head[13 +: ID_W]};
        r_s_size   <= w_head[10 +: 3];
        r_s_len    <= w_head[2 +: 8];
        r_s_burst  <= w_head[1:0];
        r_ptr      <= (w_gnt_idx == IDX_LST) ? '0 : w_gnt_idx + IDX_ONE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             r_err <= 1'b0;
    else if (w_done_bad) r_err <= 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_MST; i++) outstanding[i*CW +: CW] = r_cnt[i];
  end

  assign s_valid  = r_s_valid;
  assign s_addr   = r_s_addr;
  assign s_mid_id = r_s_mid_id;
  assign s_size   = r_s_size;
  assign s_len    = r_s_len;
  assign s_burst  = r_s_burst;
  assign err      = r_err;

endmodule
